fetch_instruction: RTL and testbench
====================================

# fetch_instruction

Instruction fetch stage: owns the PC, issues word reads to instruction memory, and delivers one 16-bit instruction at a time to the decode stage through a valid/ready handshake. It is the producer end of the instruction bus that decode consumes. It also absorbs memory wait states, flushes on a redirect from execute, and stops fetching after a HALT.

## Interface
- `START_PC`, default 16'h0000: PC loaded at reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imemRd`  out  1  read request to instruction memory.
- `imemAddr`  out  16  read address; equals the current PC.
- `imemData`  in  16  read data; valid when `imemReady`=1.
- `imemReady`  in  1  memory completes the outstanding read this cycle.
- `redirect`  in  1  execute resolved a taken branch or jump.
- `redirectPC`  in  16  target PC, sampled when `redirect`=1.
- `instruction`  out  16  registered instruction to decode.
- `instPCPlus2`  out  16  address of `instruction` + 2, used for the link value.
- `instValid`  out  1  `instruction` holds a live instruction.
- `instReady`  in  1  decode accepts `instruction` this cycle.
- `halted`  out  1  HALT was accepted; fetch is stopped.
- `err`  out  1  sticky error.

## Operation
- States: FETCH (no read outstanding), WAIT (read outstanding), DROP (outstanding read will be discarded), HALTED.
- Output slot is free when `instValid`=0, or when `instValid`&`instReady`=1.
- FETCH:
  - `imemRd`=slot free.
  - If `imemRd`&`imemReady`: capture data into the slot, set `instValid`, PC+=2, stay in FETCH.
  - If `imemRd`&!`imemReady`: go to WAIT.
- WAIT:
  - `imemRd`=1 and `imemAddr` is held stable.
  - On `imemReady`: capture, PC+=2, go to FETCH.
- A HALT capture (opcode[15:11]=5'b00000) goes to HALTED instead of FETCH. The HALT is still delivered to decode.
- HALTED:
  - `imemRd`=0, and PC and the slot are frozen except for the decode handshake.
  - `halted`=1 from the cycle after the HALT is accepted.
  - Left only by `rst`.
- `redirect` (ignored in HALTED) has priority over every other event:
  - PC<=`redirectPC` and `instValid`<=0. The slot is flushed even if decode accepts it that cycle.
  - If a read is outstanding and `imemReady`=0, go to DROP. Otherwise go to FETCH and discard any returning data.
  - If the returning data is a HALT, it is discarded and HALTED is not entered.
- DROP:
  - `imemRd`=1 with the old address.
  - On `imemReady`, discard the data and go to FETCH.
  - A further `redirect` in DROP updates PC and stays in DROP.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000 without error.

## Timing
- Reset values: PC=`START_PC`, state=FETCH, `instruction`=16'h0800 (NOP), `instPCPlus2`=0, `instValid`=0, `halted`=0, `err`=0, `imemRd`=0.
- The first `imemRd` is asserted in the first cycle after `rst` deasserts.
- Latency: `imemReady` edge to `instValid`=1 is 1 cycle. With a zero-wait memory and `instReady` tied high, throughput is one instruction per cycle.
- A redirect takes effect at the edge where it is sampled. The first read of the target address is issued the next cycle, or after DROP completes.
- `rst` in any state restores the reset values on the same edge and abandons any outstanding read.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A `redirect` with `redirectPC[0]`=1 sets `err`, flushes the slot and enters HALTED.
  - `halted` asserts the next cycle.
- Macro undefined:
  - `redirectPC[0]` is forced to 0 when loaded.
  - `err` is tied to 0.

## Structure
- Shared package holds:
  - Opcode constants `OP_HALT`=5'b00000 and `OP_NOP`=5'b00001.
  - The NOP word 16'h0800.
  - The fetch state encoding (2 bits).
- Sub-module `pc_reg`: 16-bit register with synchronous reset to `START_PC` and a load enable, built from the team's dff cell. The FSM, slot and adder stay in `fetch_instruction`.

## Test plan
- Reset, zero-wait memory with `mem[0]`=16'h4001, `instReady`=1 → `imemAddr` 0,2,4 on consecutive cycles; first `instValid` 2 cycles after reset release with `instruction`=16'h4001 and `instPCPlus2`=2.
- `imemReady` delayed 3 cycles → `imemAddr` stable for 4 cycles, `imemRd` held, exactly one instruction delivered, PC advances once.
- `instReady`=0 for 5 cycles with `instValid`=1 → `instruction` unchanged, `imemRd`=0 once the slot is full, no lost or duplicated instruction.
- `redirect` to 16'h0040 while in WAIT → the old data is dropped on `imemReady`; the next `imemAddr` is 16'h0040 and the next `instPCPlus2` is 16'h0042.
- HALT word at address 6 → delivered to decode, then `imemRd`=0 forever and `halted`=1 the cycle after acceptance; a later `redirect` is ignored.
- `redirect` to 16'h0011:
  - With `FETCH_ALIGN_CHECK_EN` defined → `err`=1 and `halted`=1.
  - Without the macro → the next `imemAddr` is 16'h0010.

Source files
------------

// File: rtl/fetch_instruction_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, NOP word, fetch state encoding.
package fetch_instruction_pkg;

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 5;

    localparam logic [OPW-1:0]  OP_HALT  = 5'b00000;
    localparam logic [OPW-1:0]  OP_NOP   = 5'b00001;
    localparam logic [XLEN-1:0] NOP_WORD = 16'h0800;
    localparam logic [XLEN-1:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DROP   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [XLEN-1:0] word);
        return word[XLEN-1:XLEN-OPW] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_instruction_pc_reg.sv
// Program counter register: synchronous reset to START_PC, loads d when load is high.
module pc_reg
    import fetch_instruction_pkg::*;
#(
    parameter logic [XLEN-1:0] START_PC = 16'h0000
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= START_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_instruction.sv
// Instruction fetch stage: PC ownership, imem reads with wait states, redirect flush, HALT stop.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_instruction
    import fetch_instruction_pkg::*;
#(
    parameter logic [15:0] START_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imemRd,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemReady,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    output logic [15:0] instruction,
    output logic [15:0] instPCPlus2,
    output logic        instValid,
    input  logic        instReady,
    output logic        halted,
    output logic        err
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus2;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] drop_addr;
    logic [XLEN-1:0] redirect_target;
    logic            pc_load;
    logic            slot_free;
    logic            redirect_act;
    logic            align_err;
    logic            outstanding;
    logic            capture;

    assign pc_plus2     = pc + PC_STEP;
    assign slot_free    = !instValid || instReady;
    assign redirect_act = redirect && (state != ST_HALTED);
    assign outstanding  = (state == ST_WAIT) || (state == ST_DROP) ||
                          ((state == ST_FETCH) && imemRd);
    // Returning data is only kept when no redirect lands in the same cycle.
    assign capture      = !redirect_act && imemReady &&
                          (((state == ST_FETCH) && imemRd) || (state == ST_WAIT));

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_err       = redirect_act && redirectPC[0];
    assign redirect_target = redirectPC;
`else
    assign align_err       = 1'b0;
    assign redirect_target = redirectPC & 16'hFFFE;
`endif

    assign pc_load = (redirect_act && !align_err) || capture;
    assign pc_next = redirect_act ? redirect_target : pc_plus2;

    pc_reg #(
        .START_PC (START_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (imemRd && imemReady) begin
                    state_next = is_halt(imemData) ? ST_HALTED : ST_FETCH;
                end else if (imemRd) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imemReady) begin
                    state_next = is_halt(imemData) ? ST_HALTED : ST_FETCH;
                end
            end
            ST_DROP: begin
                if (imemReady) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_HALTED;
        endcase
        if (redirect_act) begin
            if (align_err) begin
                state_next = ST_HALTED;
            end else if (outstanding && !imemReady) begin
                state_next = ST_DROP;
            end else begin
                state_next = ST_FETCH;
            end
        end
    end

    // Memory request outputs; DROP keeps presenting the abandoned address until it completes
    always_comb begin
        imemRd   = 1'b0;
        imemAddr = pc;
        case (state)
            ST_FETCH: imemRd = slot_free;
            ST_WAIT:  imemRd = 1'b1;
            ST_DROP: begin
                imemRd   = 1'b1;
                imemAddr = drop_addr;
            end
            default:  imemRd = 1'b0;
        endcase
        if (rst) begin
            imemRd = 1'b0;
        end
    end

    // Output slot, halt flag and the address of any read being abandoned
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_WORD;
            instPCPlus2 <= '0;
            instValid   <= 1'b0;
            halted      <= 1'b0;
            drop_addr   <= START_PC;
        end else begin
            if (redirect_act) begin
                instValid <= 1'b0;
                if (state != ST_DROP) begin
                    drop_addr <= pc;
                end
            end else if (capture) begin
                instruction <= imemData;
                instPCPlus2 <= pc_plus2;
                instValid   <= 1'b1;
            end else if (instValid && instReady) begin
                instValid <= 1'b0;
            end
            if (align_err || ((state == ST_HALTED) && slot_free)) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (align_err) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_instruction.sv
// Scoreboard bench for fetch_instruction: expected deliveries queued by stimulus, checked by a monitor.
module tb_fetch_instruction;

    logic        clk;
    logic        rst;
    logic        imemRd;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemReady;
    logic        redirect;
    logic [15:0] redirectPC;
    logic [15:0] instruction;
    logic [15:0] instPCPlus2;
    logic        instValid;
    logic        instReady;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:32767];
    int unsigned wait_cfg;
    int unsigned wcnt;
    logic [31:0] exp_q [$];
    int          n_pass;
    int          n_total;

    fetch_instruction #(.START_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imemRd      (imemRd),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .imemReady   (imemReady),
        .redirect    (redirect),
        .redirectPC  (redirectPC),
        .instruction (instruction),
        .instPCPlus2 (instPCPlus2),
        .instValid   (instValid),
        .instReady   (instReady),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory with a configurable number of wait cycles per read
    assign imemData  = mem[15'(imemAddr >> 1)];
    assign imemReady = imemRd && (wcnt >= wait_cfg);

    always @(posedge clk) begin
        if (rst || !imemRd || imemReady) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Monitor: every decode handshake must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && instValid === 1'b1 && instReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_delivery: got %h/%h want none", instruction, instPCPlus2);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("deliver_instr", {16'h0, instruction}, {16'h0, e[31:16]});
                chk("deliver_pcp2", {16'h0, instPCPlus2}, {16'h0, e[15:0]});
            end
        end
    end

    task automatic load_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 16'h4000 | (16'(i << 1) & 16'h07FF);
        mem[0] = 16'h4001;
    endtask

    task automatic do_reset(input int unsigned w, input logic rdy);
        rst = 1'b1;
        redirect = 1'b0;
        wait_cfg = w;
        instReady = rdy;
        @(posedge clk);
        @(negedge clk);
        chk("rst_instr", {16'h0, instruction}, 32'h0800);
        chk("rst_pcp2", {16'h0, instPCPlus2}, 32'h0);
        chk("rst_valid", {31'h0, instValid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rd", {31'h0, imemRd}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 80 && halted !== 1'b1; i++) @(negedge clk);
        chk("halted_reached", {31'h0, halted}, 32'h1);
        chk("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        redirect = 1'b0;
        redirectPC = 16'h0;
        instReady = 1'b1;
        wait_cfg = 0;

        // Zero-wait stream ending in HALT at 6, then a redirect that must be ignored
        load_mem();
        mem[3] = 16'h0006;
        exp_q.push_back({16'h4001, 16'h0002});
        exp_q.push_back({16'h4002, 16'h0004});
        exp_q.push_back({16'h4004, 16'h0006});
        exp_q.push_back({16'h0006, 16'h0008});
        do_reset(0, 1'b1);
        @(negedge clk);
        chk("t1_addr0", {16'h0, imemAddr}, 32'h0);
        chk("t1_rd0", {31'h0, imemRd}, 32'h1);
        chk("t1_valid0", {31'h0, instValid}, 32'h0);
        @(negedge clk);
        chk("t1_addr2", {16'h0, imemAddr}, 32'h2);
        chk("t1_first_valid", {31'h0, instValid}, 32'h1);
        chk("t1_first_instr", {16'h0, instruction}, 32'h4001);
        chk("t1_first_pcp2", {16'h0, instPCPlus2}, 32'h2);
        @(negedge clk);
        chk("t1_addr4", {16'h0, imemAddr}, 32'h4);
        @(negedge clk);
        chk("t1_addr6", {16'h0, imemAddr}, 32'h6);
        @(negedge clk);
        chk("t1_halt_slot", {16'h0, instruction}, 32'h0006);
        chk("t1_halt_rd", {31'h0, imemRd}, 32'h0);
        chk("t1_halted_early", {31'h0, halted}, 32'h0);
        @(negedge clk);
        chk("t1_halted", {31'h0, halted}, 32'h1);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirectPC = 16'h0040;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("t1_ign_rd", {31'h0, imemRd}, 32'h0);
        chk("t1_ign_addr", {16'h0, imemAddr}, 32'h8);
        chk("t1_ign_halted", {31'h0, halted}, 32'h1);
        chk("t1_queue", exp_q.size(), 32'h0);

        // Three wait states: address held four cycles, one delivery
        load_mem();
        mem[1] = 16'h0002;
        exp_q.push_back({16'h4001, 16'h0002});
        exp_q.push_back({16'h0002, 16'h0004});
        do_reset(3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_addr_hold", {16'h0, imemAddr}, 32'h0);
            chk("t2_rd_hold", {31'h0, imemRd}, 32'h1);
            chk("t2_no_valid", {31'h0, instValid}, 32'h0);
        end
        @(negedge clk);
        chk("t2_valid", {31'h0, instValid}, 32'h1);
        chk("t2_pc_once", {16'h0, imemAddr}, 32'h2);
        wait_halted();

        // Decode backpressure for five cycles
        load_mem();
        mem[2] = 16'h0004;
        exp_q.push_back({16'h4001, 16'h0002});
        exp_q.push_back({16'h4002, 16'h0004});
        exp_q.push_back({16'h0004, 16'h0006});
        do_reset(0, 1'b0);
        @(negedge clk);
        chk("t3_rd", {31'h0, imemRd}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_valid", {31'h0, instValid}, 32'h1);
            chk("t3_stall_instr", {16'h0, instruction}, 32'h4001);
            chk("t3_stall_rd", {31'h0, imemRd}, 32'h0);
        end
        @(posedge clk);
        #1 instReady = 1'b1;
        @(negedge clk);
        chk("t3_resume_rd", {31'h0, imemRd}, 32'h1);
        chk("t3_resume_addr", {16'h0, imemAddr}, 32'h2);
        wait_halted();

        // Redirect while a read is waiting: old data dropped
        load_mem();
        mem[16'h42 >> 1] = 16'h0042;
        exp_q.push_back({16'h4040, 16'h0042});
        exp_q.push_back({16'h0042, 16'h0044});
        do_reset(2, 1'b1);
        @(negedge clk);
        chk("t4_addr0", {16'h0, imemAddr}, 32'h0);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirectPC = 16'h0040;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("t4_drop_addr", {16'h0, imemAddr}, 32'h0);
        chk("t4_drop_rd", {31'h0, imemRd}, 32'h1);
        chk("t4_drop_valid", {31'h0, instValid}, 32'h0);
        @(negedge clk);
        chk("t4_target_addr", {16'h0, imemAddr}, 32'h40);
        chk("t4_target_rd", {31'h0, imemRd}, 32'h1);
        wait_halted();

        // Misaligned redirect
        load_mem();
        mem[16'h12 >> 1] = 16'h0012;
`ifndef FETCH_ALIGN_CHECK_EN
        exp_q.push_back({16'h4010, 16'h0012});
        exp_q.push_back({16'h0012, 16'h0014});
`endif
        do_reset(0, 1'b1);
        redirect = 1'b1;
        redirectPC = 16'h0011;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t5_err", {31'h0, err}, 32'h1);
        chk("t5_halted", {31'h0, halted}, 32'h1);
        chk("t5_rd", {31'h0, imemRd}, 32'h0);
        chk("t5_valid", {31'h0, instValid}, 32'h0);
`else
        chk("t5_addr", {16'h0, imemAddr}, 32'h10);
        chk("t5_rd", {31'h0, imemRd}, 32'h1);
        chk("t5_err", {31'h0, err}, 32'h0);
`endif
        wait_halted();

        // PC wrap from 16'hFFFE
        load_mem();
        mem[1] = 16'h0002;
        exp_q.push_back({16'h47FE, 16'h0000});
        exp_q.push_back({16'h4001, 16'h0002});
        exp_q.push_back({16'h0002, 16'h0004});
        do_reset(0, 1'b1);
        redirect = 1'b1;
        redirectPC = 16'hFFFE;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("t6_addr_top", {16'h0, imemAddr}, 32'hFFFE);
        @(negedge clk);
        chk("t6_addr_wrap", {16'h0, imemAddr}, 32'h0);
        chk("t6_pcp2_wrap", {16'h0, instPCPlus2}, 32'h0);
        chk("t6_err", {31'h0, err}, 32'h0);
        wait_halted();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
